// File: rtl/seq_det_pkg.sv
// Shared types and default sizes for the serial sequence detector.
package seq_det_pkg;

    localparam int unsigned PAT_W_DEF = 4;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_det_core.sv
// Shift register, history count and pattern compare for the sequence detector.
// hit is combinational: it flags that the bit being shifted in this cycle
// completes a match.
module seq_det_core #(
    parameter int unsigned PAT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             hit
);

    localparam int unsigned HIST_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0]  shreg;
    logic [PAT_W-1:0]  shreg_nxt;
    logic [HIST_W-1:0] hist;
    logic [HIST_W-1:0] hist_nxt;

    // Next shift value, saturating history count and match compare
    always_comb begin
        shreg_nxt = {shreg[PAT_W-2:0], bit_in};
        hist_nxt  = (hist == HIST_W'(PAT_W)) ? hist : hist + HIST_W'(1);
        hit       = shift_en && (hist_nxt == HIST_W'(PAT_W)) && (shreg_nxt == pattern);
    end

    // Shift on each accepted bit; non-overlapping mode restarts history after a hit
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shreg <= '0;
            hist  <= '0;
        end else if (shift_en) begin
            shreg <= shreg_nxt;
            hist  <= (hit && !overlap) ? '0 : hist_nxt;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller for the serial sequence detector: configuration latch,
// IDLE/RUN/DONE sequencing, match pulse and saturating match counter.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_thresh,
    input  logic             start,
    input  logic             stop,
    input  logic             ack,
    input  logic             in,
    input  logic             in_valid,
    output logic             busy,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             done
);

    state_t           state;
    logic [PAT_W-1:0] pattern;
    logic             overlap;
    logic [CNT_W-1:0] thresh;

    logic             shift_en_c;
    logic             clear_c;
    logic             hit_c;
    logic [CNT_W-1:0] cnt_inc_c;

    // A stop in RUN discards the coincident bit
    assign shift_en_c = (state == ST_RUN) && in_valid && !stop;
    assign clear_c    = (state == ST_IDLE) && start;
    assign cnt_inc_c  = (match_cnt == '1) ? match_cnt : match_cnt + CNT_W'(1);

    seq_det_core #(
        .PAT_W (PAT_W)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear_c),
        .shift_en (shift_en_c),
        .bit_in   (in),
        .pattern  (pattern),
        .overlap  (overlap),
        .hit      (hit_c)
    );

    // Run FSM with registered status outputs and match counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            pattern   <= '0;
            overlap   <= 1'b0;
            thresh    <= '0;
            busy      <= 1'b0;
            match     <= 1'b0;
            match_cnt <= '0;
            done      <= 1'b0;
        end else begin
            match <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_we) begin
                        pattern <= cfg_pattern;
                        overlap <= cfg_overlap;
                        thresh  <= cfg_thresh;
                    end
                    if (start) begin
                        state     <= ST_RUN;
                        busy      <= 1'b1;
                        match_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (hit_c) begin
                        match     <= 1'b1;
                        match_cnt <= cnt_inc_c;
                        if ((thresh != '0) && (cnt_inc_c == thresh)) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (ack) begin
                        state <= ST_IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed scenarios plus randomized traffic checked
// every cycle against a bit-queue reference model.
module tb_seq_det_ctrl;

    localparam int unsigned PAT_W   = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cfg_we = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic             cfg_overlap = 1'b0;
    logic [CNT_W-1:0] cfg_thresh = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             ack = 1'b0;
    logic             in = 1'b0;
    logic             in_valid = 1'b0;
    logic             busy;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             done;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 idle, 1 run, 2 done; received bits kept oldest-first
    int m_state = 0;
    int m_pat   = 0;
    int m_ovl   = 0;
    int m_thr   = 0;
    int m_cnt   = 0;
    int m_match = 0;
    bit q[$];

    int hit_mask;
    bit stream [17] = '{1,0,1,0,1,0,1,0,0,1,1,0,1,0,0,1,0};

    seq_det_ctrl #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_overlap (cfg_overlap),
        .cfg_thresh  (cfg_thresh),
        .start       (start),
        .stop        (stop),
        .ack         (ack),
        .in          (in),
        .in_valid    (in_valid),
        .busy        (busy),
        .match       (match),
        .match_cnt   (match_cnt),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int window_value();
        int v = 0;
        foreach (q[i]) v = v * 2 + int'(q[i]);
        return v;
    endfunction

    // Advance the model by one clock using the inputs sampled at that edge
    task automatic model_step();
        m_match = 0;
        if (reset) begin
            m_state = 0; m_pat = 0; m_ovl = 0; m_thr = 0; m_cnt = 0;
            q.delete();
        end else begin
            case (m_state)
                0: begin
                    if (cfg_we) begin
                        m_pat = int'(cfg_pattern);
                        m_ovl = int'(cfg_overlap);
                        m_thr = int'(cfg_thresh);
                    end
                    if (start) begin
                        m_state = 1;
                        m_cnt   = 0;
                        q.delete();
                    end
                end
                1: begin
                    if (stop) begin
                        m_state = 0;
                    end else if (in_valid) begin
                        q.push_back(in);
                        if (q.size() > PAT_W) void'(q.pop_front());
                        if (q.size() == PAT_W && window_value() == m_pat) begin
                            m_match = 1;
                            if (m_cnt < CNT_MAX) m_cnt++;
                            if (m_ovl == 0) q.delete();
                            if (m_thr != 0 && m_cnt == m_thr) m_state = 2;
                        end
                    end
                end
                default: if (ack) m_state = 0;
            endcase
        end
    endtask

    // One clock: model update, output comparison, then release pulse inputs
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("busy",      busy,      32'(m_state == 1));
        chk("done",      done,      32'(m_state == 2));
        chk("match",     match,     32'(m_match));
        chk("match_cnt", match_cnt, 32'(m_cnt));
        reset = 0; cfg_we = 0; start = 0; stop = 0; ack = 0; in_valid = 0;
    endtask

    task automatic configure(input int pat, input bit ovl, input int thr, input bit with_start);
        cfg_we      = 1'b1;
        cfg_pattern = PAT_W'(pat);
        cfg_overlap = ovl;
        cfg_thresh  = CNT_W'(thr);
        start       = with_start;
        step();
    endtask

    task automatic send_bit(input bit b);
        in = b; in_valid = 1'b1;
        step();
    endtask

    task automatic run_stream();
        hit_mask = 0;
        for (int i = 0; i < 17; i++) begin
            send_bit(stream[i]);
            if (match === 1'b1) hit_mask |= (1 << i);
        end
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_match", match, 0);
        chk("rst_cnt", match_cnt, 0);

        // Overlapping, free-running
        configure(4'b1010, 1'b1, 0, 1'b1);
        run_stream();
        chk("ovl_hits", hit_mask, 32'h20A8);
        chk("ovl_cnt", match_cnt, 4);
        chk("ovl_busy", busy, 1);
        stop = 1'b1; step();
        chk("ovl_stop_busy", busy, 0);
        chk("ovl_cnt_held", match_cnt, 4);

        // Non-overlapping
        configure(4'b1010, 1'b0, 0, 1'b1);
        run_stream();
        chk("novl_hits", hit_mask, 32'h2088);
        chk("novl_cnt", match_cnt, 3);
        stop = 1'b1; step();

        // Threshold of two ends the run at bit 5
        configure(4'b1010, 1'b1, 2, 1'b1);
        run_stream();
        chk("thr_hits", hit_mask, 32'h0028);
        chk("thr_done", done, 1);
        chk("thr_cnt", match_cnt, 2);
        start = 1'b1; step();
        chk("done_ignores_start", done, 1);
        stop = 1'b1; step();
        chk("done_ignores_stop", done, 1);
        ack = 1'b1; step();
        chk("ack_done", done, 0);
        chk("ack_cnt_held", match_cnt, 2);

        // Stop coincident with the completing bit
        configure(4'b1010, 1'b1, 0, 1'b1);
        send_bit(1); send_bit(0); send_bit(1);
        in = 1'b0; in_valid = 1'b1; stop = 1'b1; step();
        chk("stop_match", match, 0);
        chk("stop_busy", busy, 0);
        chk("stop_cnt", match_cnt, 0);
        step();
        chk("stop_no_late_match", match, 0);

        // Config write during RUN is ignored
        configure(4'b1010, 1'b0, 0, 1'b1);
        send_bit(1); send_bit(0);
        cfg_we = 1'b1; cfg_pattern = 4'b1111; cfg_thresh = 4'd1;
        send_bit(1);
        send_bit(0);
        chk("cfg_in_run_match", match, 1);
        chk("cfg_in_run_busy", busy, 1);

        // Reset mid-run after 1,0,1
        configure(4'b1010, 1'b1, 0, 1'b1);
        send_bit(1); send_bit(0); send_bit(1);
        reset = 1'b1; step();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt", match_cnt, 0);
        // Cleared config: pattern 0000, non-overlapping, free-running
        start = 1'b1; step();
        for (int i = 0; i < 8; i++) send_bit(0);
        chk("rst_pattern_zero_cnt", match_cnt, 2);
        chk("rst_pattern_busy", busy, 1);
        stop = 1'b1; step();

        // Config together with start applies to that run
        configure(4'b0110, 1'b0, 1, 1'b1);
        send_bit(0); send_bit(1); send_bit(1); send_bit(0);
        chk("cfg_start_done", done, 1);
        chk("cfg_start_cnt", match_cnt, 1);
        ack = 1'b1; step();

        // Counter saturation
        configure(4'b0000, 1'b1, 0, 1'b1);
        for (int i = 0; i < 22; i++) send_bit(0);
        chk("sat_cnt", match_cnt, CNT_MAX);
        stop = 1'b1; step();

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            reset       = ($urandom_range(0, 299) == 0);
            cfg_we      = ($urandom_range(0, 7) == 0);
            cfg_pattern = PAT_W'($urandom_range(0, (1 << PAT_W) - 1));
            cfg_overlap = 1'($urandom_range(0, 1));
            cfg_thresh  = CNT_W'($urandom_range(0, 5));
            start       = ($urandom_range(0, 9) == 0);
            stop        = ($urandom_range(0, 59) == 0);
            ack         = ($urandom_range(0, 5) == 0);
            in          = 1'($urandom_range(0, 1));
            in_valid    = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 SHALL have parameter PAT_W, default 4, meaning pattern length in bits (2..8).
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of the match counter and threshold.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port cfg_we, input, 1 bit: configuration write strobe.
REQ-006 SHALL have port cfg_pattern, input, PAT_W bits: target pattern, MSB is the first bit received.
REQ-007 SHALL have port cfg_overlap, input, 1 bit: 1 means overlapping matches, 0 means non-overlapping.
REQ-008 SHALL have port cfg_thresh, input, CNT_W bits: match count that ends a run; 0 means free-running.
REQ-009 SHALL have port start, input, 1 bit: begin a detection run.
REQ-010 SHALL have port stop, input, 1 bit: abort the current run.
REQ-011 SHALL have port ack, input, 1 bit: acknowledge done.
REQ-012 SHALL have port in, input, 1 bit: serial data bit.
REQ-013 SHALL have port in_valid, input, 1 bit: in is sampled this cycle.
REQ-014 SHALL have port busy, output, 1 bit: high in RUN.
REQ-015 SHALL have port match, output, 1 bit: one-cycle pulse per detected pattern.
REQ-016 SHALL have port match_cnt, output, CNT_W bits: matches counted in the current or last run.
REQ-017 SHALL have port done, output, 1 bit: level, high in DONE.

Function
REQ-018 SHALL implement FSM states IDLE, RUN and DONE.
REQ-019 In IDLE, cfg_we SHALL latch cfg_pattern, cfg_overlap and cfg_thresh; cfg_we in RUN or DONE SHALL be ignored.
REQ-020 In IDLE, start SHALL enter RUN next cycle and clear the shift register, the history count and match_cnt; if cfg_we and start coincide, the new configuration SHALL apply to that run.
REQ-021 In RUN, each in_valid cycle SHALL shift in into the LSB of a PAT_W shift register; the history count SHALL saturate at PAT_W; cycles without in_valid SHALL hold all state.
REQ-022 A match SHALL occur when the history count including the current bit is PAT_W and the shifted value equals the pattern; match SHALL pulse on the cycle after that in_valid (latency 1).
REQ-023 On a match with overlap=0, the history count SHALL clear to 0; with overlap=1, the history SHALL be retained.
REQ-024 Each match SHALL increment match_cnt; match_cnt SHALL saturate at all-ones.
REQ-025 With thresh≠0, the match that brings match_cnt to thresh SHALL move the FSM to DONE in the same edge as the match pulse; later bits SHALL be ignored.
REQ-026 With thresh=0, the FSM SHALL remain in RUN until stop.
REQ-027 In RUN, stop SHALL return to IDLE next cycle with no match pulse; a coincident in_valid bit SHALL be discarded; match_cnt SHALL be held.
REQ-028 In DONE, ack SHALL return to IDLE; start in DONE SHALL be ignored; stop in IDLE or DONE SHALL be ignored.
REQ-029 match_cnt SHALL hold its value in IDLE and DONE until the next start.

Reset
REQ-030 Reset SHALL force IDLE, busy=0, match=0, done=0, match_cnt=0, shift register and history count to 0, pattern to 0, overlap to 0 and thresh to 0.
REQ-031 Reset SHALL take priority over every other input, including mid-run.

Structure
REQ-032 Package seq_det_pkg SHALL hold the state enumeration and the default PAT_W and CNT_W constants.
REQ-033 Sub-module seq_det_core SHALL contain the shift register, history count and compare logic, and output a combinational hit; the FSM and counter SHALL stay in seq_det_ctrl.

Verification
REQ-034 Config 1010, overlap=1, thresh=0, start, then stream 1,0,1,0,1,0,1,0,0,1,1,0,1,0,0,1,0 with in_valid=1 -> match pulses after bits 3, 5, 7 and 13; match_cnt=4.
REQ-035 Same stream with overlap=0 -> match pulses after bits 3, 7 and 13; match_cnt=3.
REQ-036 Overlap=1, thresh=2, same stream -> done high after bit 5 with match_cnt=2; later bits ignored; ack -> IDLE, done=0.
REQ-037 Stop asserted with in_valid on bit 3 of the 1010 stream -> no match; IDLE next cycle; match_cnt=0.
REQ-038 Reset asserted mid-run after bits 1,0,1 -> all outputs 0 and pattern=0 next cycle; a cfg_we in RUN leaves the pattern unchanged.
